// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - requester and downstream cache signals for cache_arbiter
interface cache_arbiter_if;
    logic        req0, req1, wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        miss0, miss1, err0, err1;
    logic [31:0] c_addr, c_data;
    logic        c_wr, c_valid;
    logic        c_response, c_missrate;
    logic [31:0] c_out;
    logic        busy;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        input  c_response, c_missrate, c_out,
        output ack0, ack1, rdata0, rdata1, miss0, miss1, err0, err1,
        output c_addr, c_data, c_wr, c_valid, busy
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        output c_response, c_missrate, c_out,
        input  ack0, ack1, rdata0, rdata1, miss0, miss1, err0, err1,
        input  c_addr, c_data, c_wr, c_valid, busy
    );
endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-port round-robin arbiter in front of a single cache port
module cache_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    cache_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [8:0] TO9 = 9'(TIMEOUT);

    state_t     r_state;
    logic       r_last;
    logic       r_port;
    logic [7:0] r_cnt;

    logic       w_any;
    logic       w_grant;
    logic [8:0] w_cnt_nxt;

    // On a tie the port not served last wins; r_last resets to 1 so port 0 wins first.
    always_comb begin
        w_any     = bus.req0 | bus.req1;
        w_grant   = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
        w_cnt_nxt = {1'b0, r_cnt} + 9'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_port     <= 1'b0;
            r_cnt      <= '0;
            bus.ack0   <= 1'b0;
            bus.ack1   <= 1'b0;
            bus.rdata0 <= '0;
            bus.rdata1 <= '0;
            bus.miss0  <= 1'b0;
            bus.miss1  <= 1'b0;
            bus.err0   <= 1'b0;
            bus.err1   <= 1'b0;
            bus.c_addr <= '0;
            bus.c_data <= '0;
            bus.c_wr   <= 1'b0;
            bus.c_valid <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            bus.ack0    <= 1'b0;
            bus.ack1    <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
            bus.miss0   <= 1'b0;
            bus.miss1   <= 1'b0;
            bus.err0    <= 1'b0;
            bus.err1    <= 1'b0;
            bus.c_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_port      <= w_grant;
                        r_last      <= w_grant;
                        bus.c_addr  <= w_grant ? bus.addr1  : bus.addr0;
                        bus.c_data  <= w_grant ? bus.wdata1 : bus.wdata0;
                        bus.c_wr    <= w_grant ? bus.wr1    : bus.wr0;
                        bus.c_valid <= 1'b1;
                        bus.busy    <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus.c_response) begin
                        r_state <= RESP;
                        if (r_port) begin
                            bus.ack1   <= 1'b1;
                            bus.rdata1 <= bus.c_wr ? '0 : bus.c_out;
                            bus.miss1  <= bus.c_missrate;
                        end else begin
                            bus.ack0   <= 1'b1;
                            bus.rdata0 <= bus.c_wr ? '0 : bus.c_out;
                            bus.miss0  <= bus.c_missrate;
                        end
                    end else if (w_cnt_nxt >= TO9) begin
                        // Counter pins at TIMEOUT; the transaction ends with an error and no data.
                        r_cnt   <= TO9[7:0];
                        r_state <= RESP;
                        if (r_port) begin
                            bus.ack1 <= 1'b1;
                            bus.err1 <= 1'b1;
                        end else begin
                            bus.ack0 <= 1'b1;
                            bus.err0 <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt[7:0];
                    end
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter with a transaction-level model
module tb_cache_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    cache_arbiter_if bus();
    cache_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cout;
        logic        ms;
        int          k;
        bit          drop;
        logic [31:0] e_rdata;
        logic        e_miss;
        logic        e_err;
        int          e_lat;
    } txn_t;

    txn_t exp_iss[$];
    txn_t exp_ack[$];

    int n_chk = 0, n_pass = 0, n_tofail = 0;

    // Requests are levels derived from per-port counters so each counter has a single writer.
    int arm0 = 0, arm1 = 0, ackc0 = 0, ackc1 = 0, drop0 = -1, drop1 = -1;
    logic        t_wr[2];
    logic [31:0] t_addr[2];
    logic [31:0] t_wdata[2];
    bit          last_g = 1'b1;

    assign bus.req0   = (arm0 != ackc0) && (arm0 != drop0);
    assign bus.req1   = (arm1 != ackc1) && (arm1 != drop1);
    assign bus.wr0    = t_wr[0];
    assign bus.wr1    = t_wr[1];
    assign bus.addr0  = t_addr[0];
    assign bus.addr1  = t_addr[1];
    assign bus.wdata0 = t_wdata[0];
    assign bus.wdata1 = t_wdata[1];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Monitor and downstream cache responder.
    txn_t cur, e;
    bit   rs_active = 1'b0;
    int   rs_w = 0;
    int   iss_cyc = 0;
    bit   cv_prev = 1'b0;
    bit   busy_chk = 1'b0;

    always @(negedge clk) begin
        if (rst_q) begin
            chk("rst_flags", 32'({bus.ack0, bus.ack1, bus.miss0, bus.miss1, bus.err0, bus.err1,
                                  bus.busy, bus.c_valid, bus.c_wr}), 32'd0);
            chk("rst_rdata", bus.rdata0 | bus.rdata1, 32'd0);
            chk("rst_caddr", bus.c_addr | bus.c_data, 32'd0);
            rs_active      = 1'b0;
            busy_chk       = 1'b0;
            bus.c_response = 1'b0;
            bus.c_missrate = 1'b0;
            bus.c_out      = '0;
        end else begin
            if (!bus.ack0) chk("quiet0", 32'({bus.rdata0 != 0, bus.miss0, bus.err0}), 32'd0);
            if (!bus.ack1) chk("quiet1", 32'({bus.rdata1 != 0, bus.miss1, bus.err1}), 32'd0);

            if (bus.c_valid) begin
                chk("cvalid_one_cycle", 32'(cv_prev), 32'd0);
                if (exp_iss.size() == 0) begin
                    chk("unexpected_issue", 32'd1, 32'd0);
                    rs_active = 1'b0;
                end else begin
                    cur = exp_iss.pop_front();
                    chk("issue_addr", bus.c_addr, cur.addr);
                    chk("issue_data", bus.c_data, cur.data);
                    chk("issue_wr", 32'(bus.c_wr), 32'(cur.wr));
                    iss_cyc   = cyc;
                    rs_active = (cur.k < TO);
                    rs_w      = 0;
                    if (cur.drop) begin
                        if (cur.port == 1) drop1 = arm1;
                        else               drop0 = arm0;
                    end
                end
                bus.c_response = 1'b0;
            end else if (rs_active) begin
                bus.c_response = (rs_w == cur.k);
                bus.c_out      = cur.cout;
                bus.c_missrate = cur.ms;
                if (rs_w == cur.k) rs_active = 1'b0;
                rs_w++;
            end else begin
                bus.c_response = 1'b0;
                bus.c_out      = $urandom;
                bus.c_missrate = 1'($urandom_range(0, 1));
            end

            if (bus.ack0 || bus.ack1) begin
                chk("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
                if (exp_ack.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = exp_ack.pop_front();
                    chk("ack_port", 32'(bus.ack1), 32'(e.port));
                    chk("ack_rdata", bus.ack1 ? bus.rdata1 : bus.rdata0, e.e_rdata);
                    chk("ack_miss", 32'(bus.ack1 ? bus.miss1 : bus.miss0), 32'(e.e_miss));
                    chk("ack_err", 32'(bus.ack1 ? bus.err1 : bus.err0), 32'(e.e_err));
                    chk("ack_latency", 32'(cyc - iss_cyc), 32'(e.e_lat));
                    chk("caddr_hold", bus.c_addr, e.addr);
                end
                if (bus.ack1) ackc1 = arm1;
                else          ackc0 = arm0;
                busy_chk = 1'b1;
            end else if (busy_chk) begin
                chk("busy_after_ack", 32'(bus.busy), 32'd0);
                busy_chk = 1'b0;
            end
        end
        cv_prev = bus.c_valid;
    end

    task automatic set_port(int p, logic w, logic [31:0] a, logic [31:0] d);
        t_wr[p]    = w;
        t_addr[p]  = a;
        t_wdata[p] = d;
    endtask

    // Expected outcome from the rules: response within TIMEOUT waits returns data, otherwise error.
    task automatic push_txn(int p, int k, logic [31:0] co, logic ms, bit drop);
        txn_t t;
        bit   tmo;
        tmo       = (k >= TO);
        t.port    = p;
        t.wr      = t_wr[p];
        t.addr    = t_addr[p];
        t.data    = t_wdata[p];
        t.cout    = co;
        t.ms      = ms;
        t.k       = k;
        t.drop    = drop;
        t.e_err   = tmo;
        t.e_miss  = tmo ? 1'b0 : ms;
        t.e_rdata = (tmo || t_wr[p]) ? 32'd0 : co;
        t.e_lat   = tmo ? TO + 1 : k + 2;
        exp_iss.push_back(t);
        exp_ack.push_back(t);
    endtask

    task automatic wait_done();
        int b = 0;
        while (exp_ack.size() != 0 && b < 400) begin
            @(negedge clk);
            b++;
        end
        if (exp_ack.size() != 0) begin
            $display("FAIL wait_done: %0d acks outstanding, expected 0", exp_ack.size());
            n_tofail++;
            exp_ack.delete();
            exp_iss.delete();
        end
        @(negedge clk);
    endtask

    task automatic single(int p, logic w, logic [31:0] a, logic [31:0] d, int k,
                          logic [31:0] co, logic ms);
        set_port(p, w, a, d);
        push_txn(p, k, co, ms, 1'b0);
        last_g = p[0];
        if (p == 1) arm1++; else arm0++;
        wait_done();
    endtask

    task automatic rand_round(bit u0, bit u1);
        int first, second;
        for (int p = 0; p < 2; p++)
            set_port(p, 1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00} + 32'(p << 12), $urandom);
        if (u0 && u1) begin
            first  = last_g ? 0 : 1;
            second = 1 - first;
            push_txn(first,  $urandom_range(0, TO + 1), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            push_txn(second, $urandom_range(0, TO + 1), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            last_g = second[0];
        end else begin
            first = u1 ? 1 : 0;
            push_txn(first, $urandom_range(0, TO + 1), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            last_g = first[0];
        end
        if (u0) arm0++;
        if (u1) arm1++;
        wait_done();
    endtask

    initial begin
        int b;
        set_port(0, 1'b0, 32'd0, 32'd0);
        set_port(1, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        single(0, 1'b0, 32'h40, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        single(0, 1'b0, 32'h44, 32'h0, 5, 32'h12345678, 1'b1);
        single(1, 1'b1, 32'h8, 32'hA5A5A5A5, 0, 32'h0BADF00D, 1'b1);
        single(0, 1'b0, 32'h50, 32'h0, TO + 3, 32'hFFFF0000, 1'b1);
        single(1, 1'b0, 32'h60, 32'h0, TO - 1, 32'hCAFEF00D, 1'b0);

        rand_round(1'b1, 1'b1);
        rand_round(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            rand_round(pat[0], pat[1]);
        end

        // Reset while waiting on the cache: the aborted request must be regranted.
        set_port(1, 1'b0, 32'h77C, 32'h0);
        push_txn(1, TO + 5, 32'h0, 1'b0, 1'b0);
        arm1++;
        b = 0;
        while (!bus.c_valid && b < 20) begin
            @(negedge clk);
            b++;
        end
        if (!bus.c_valid) begin
            $display("FAIL reset_test_issue: c_valid %0b expected 1", bus.c_valid);
            n_tofail++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_ack.delete();
        exp_iss.delete();
        last_g = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_txn(1, 1, 32'h13579BDF, 1'b0, 1'b0);
        wait_done();

        single(0, 1'b0, 32'h90, 32'h0, 2, 32'h2468ACE0, 1'b1);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk + n_tofail);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles before a transaction is aborted (legal range 1..255).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  the requester holds it high until its ack.
REQ-005 wr0, wr1  input  1 each  1 = write, 0 = read.
REQ-006 addr0, addr1, wdata0, wdata1  input  32 each  request address and write data, stable while the matching req is high.
REQ-007 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-008 rdata0, rdata1  output  32 each  read data, valid while the matching ack is high.
REQ-009 miss0, miss1, err0, err1  output  1 each  cache-miss flag and timeout flag, valid while the matching ack is high.
REQ-010 c_addr, c_data  output  32 each  downstream cache address and write data.
REQ-011 c_wr, c_valid  output  1 each  downstream write flag and one-cycle issue strobe.
REQ-012 c_response, c_missrate  input  1 each  downstream done level and miss flag.
REQ-013 c_out  input  32  downstream read data.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE with no req high SHALL stay in IDLE; with any req high, it SHALL grant one port, load c_addr/c_data/c_wr from that port, and go to ISSUE.
REQ-017 Arbitration SHALL be round-robin: if only one req is high, that port wins; if both are high, the port not granted last wins; after reset, port 0 wins the first tie.
REQ-018 ISSUE SHALL drive c_valid=1 for exactly one cycle, clear the wait counter to 0, and go to WAIT.
REQ-019 In WAIT with c_response=1, the block SHALL capture c_out and c_missrate and go to RESP.
REQ-020 In WAIT with c_response=0, the wait counter SHALL increment each cycle; when the counter reaches TIMEOUT, the block SHALL set the error flag and go to RESP without capturing data.
REQ-021 RESP SHALL last one cycle with these outputs on the granted port only:
- ackN=1;
- rdataN = captured c_out on a read, 0 on a write or timeout;
- missN = captured c_missrate, 0 on timeout;
- errN = 1 only on timeout.
RESP SHALL then go to IDLE.
REQ-022 reqN of the port being acknowledged SHALL be ignored during RESP; arbitration SHALL resume in the following IDLE cycle.
REQ-023 Minimum latency, with req sampled in IDLE at cycle 0 and c_response=1 in the first WAIT cycle, SHALL be ack in cycle 3; each extra WAIT cycle SHALL add one cycle.
REQ-024 Outside RESP, all ack, miss, err and rdata outputs SHALL be 0; c_valid SHALL be 0 outside ISSUE.
REQ-025 c_addr, c_data and c_wr SHALL hold their values from ISSUE until the next grant.
REQ-026 A req that drops before its ack SHALL NOT abort the transaction; the ack SHALL still be issued.
REQ-027 The wait counter SHALL be 8 bits, SHALL NOT wrap, and SHALL saturate at TIMEOUT.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL force:
- state = IDLE;
- all ack, miss, err, rdata, c_valid and busy outputs = 0;
- c_addr = c_data = 0 and c_wr = 0;
- wait counter = 0;
- round-robin pointer favoring port 0.
REQ-029 A reset during ISSUE, WAIT or RESP SHALL discard the transaction with no ack issued; the first grant after reset SHALL follow REQ-017.

Verification
REQ-030 Single read hit: req0=1, wr0=0, addr0=0x40; c_response=1 in the first WAIT cycle with c_out=0xDEADBEEF, c_missrate=0 -> ack0 in cycle 3, rdata0=0xDEADBEEF, miss0=0, err0=0.
REQ-031 Read miss: c_response held 0 for 5 WAIT cycles, then 1 with c_out=0x12345678, c_missrate=1 -> ack0 in cycle 8, rdata0=0x12345678, miss0=1.
REQ-032 Tie: req0 and req1 both high from reset -> port 0 served first, port 1 next; rearming both requests -> port 0 served after port 1, alternating.
REQ-033 Write: req1=1, wr1=1, addr1=0x8, wdata1=0xA5A5A5A5 -> in ISSUE c_addr=0x8, c_data=0xA5A5A5A5, c_wr=1, c_valid=1; ack1 asserted with rdata1=0.
REQ-034 Timeout: TIMEOUT=4 and c_response held 0 -> ack0=1, err0=1, rdata0=0 after 4 WAIT cycles; busy low in the next cycle.
REQ-035 Reset in WAIT: rst=1 for one cycle -> no ack pulse, busy=0, state IDLE; a pending req1 is granted after reset.
